// File: rtl/frame_sequencer.sv
// Shared frame sequencer: divides the clock into steps and emits registered
// quarter-frame, half-frame and frame strobes for a 4-step or 5-step sequence.
module frame_sequencer #(
  parameter int CLKS_PER_STEP = 104167,
  parameter int DIV_WIDTH     = 17
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mode,
  input  logic       i_mode_valid,
  input  logic       i_irq_inhibit,
  input  logic       i_irq_ack,
  output logic       o_quarter_frame,
  output logic       o_half_frame,
  output logic       o_frame_pulse,
  output logic       o_irq,
  output logic [2:0] o_step
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(CLKS_PER_STEP - 1);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [2:0]           step_q, step_d;
  logic                 mode_q, mode_d;
  logic                 quarter_q, quarter_d;
  logic                 half_q, half_d;
  logic                 frame_q, frame_d;
  logic                 irq_q, irq_d;
  logic                 tick;
  logic                 last_step;
  logic                 irq_set;

  assign tick      = (div_q == DIV_LAST);
  assign last_step = mode_q ? (step_q == 3'd4) : (step_q == 3'd3);

  always_comb begin
    div_d     = div_q + DIV_WIDTH'(1);
    step_d    = step_q;
    mode_d    = mode_q;
    quarter_d = 1'b0;
    half_d    = 1'b0;
    frame_d   = 1'b0;
    irq_set   = 1'b0;

    if (tick) begin
      div_d  = '0;
      step_d = last_step ? 3'd0 : step_q + 3'd1;
      case (step_q)
        3'd0, 3'd2: quarter_d = 1'b1;
        3'd1: begin
          quarter_d = 1'b1;
          half_d    = 1'b1;
        end
        3'd3: begin
          // Step 3 is the frame end in 4-step mode and silent in 5-step mode
          if (!mode_q) begin
            quarter_d = 1'b1;
            half_d    = 1'b1;
            frame_d   = 1'b1;
            irq_set   = 1'b1;
          end
        end
        3'd4: begin
          quarter_d = 1'b1;
          half_d    = 1'b1;
          frame_d   = 1'b1;
        end
        default: ;
      endcase
    end

    // A mode write restarts the sequence and discards any coincident tick
    if (i_mode_valid) begin
      mode_d    = i_mode;
      div_d     = '0;
      step_d    = 3'd0;
      quarter_d = i_mode;
      half_d    = i_mode;
      frame_d   = 1'b0;
      irq_set   = 1'b0;
    end

    irq_d = irq_q;
    if (i_irq_inhibit) begin
      irq_d = 1'b0;
    end else if (irq_set) begin
      irq_d = 1'b1;
    end else if (i_irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q     <= '0;
      step_q    <= 3'd0;
      mode_q    <= 1'b0;
      quarter_q <= 1'b0;
      half_q    <= 1'b0;
      frame_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      quarter_q <= quarter_d;
      half_q    <= half_d;
      frame_q   <= frame_d;
      irq_q     <= irq_d;
    end
  end

  assign o_quarter_frame = quarter_q;
  assign o_half_frame    = half_q;
  assign o_frame_pulse   = frame_q;
  assign o_irq           = irq_q;
  assign o_step          = step_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: directed scenarios plus randomized
// stimulus compared every cycle against an arithmetic sequence model.
module tb_frame_sequencer;

  localparam int N  = 4;
  localparam int DW = 3;

  logic       clk = 1'b0;
  logic       rstIn = 1'b1;
  logic       modeIn = 1'b0;
  logic       modeValidIn = 1'b0;
  logic       inhibitIn = 1'b0;
  logic       ackIn = 1'b0;
  logic       quarterOut, halfOut, frameOut, irqOut;
  logic [2:0] stepOut;

  always #5 clk = ~clk;

  frame_sequencer #(.CLKS_PER_STEP(N), .DIV_WIDTH(DW)) dut (
    .i_clk          (clk),
    .i_rst          (rstIn),
    .i_mode         (modeIn),
    .i_mode_valid   (modeValidIn),
    .i_irq_inhibit  (inhibitIn),
    .i_irq_ack      (ackIn),
    .o_quarter_frame(quarterOut),
    .o_half_frame   (halfOut),
    .o_frame_pulse  (frameOut),
    .o_irq          (irqOut),
    .o_step         (stepOut)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Model: cycles elapsed since the sequence restarted, plus event masks per step
  bit mMode = 1'b0;
  int mCnt  = 0;
  bit mIrq  = 1'b0;
  bit eQ = 1'b0, eH = 1'b0, eF = 1'b0;
  int eStep = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelUpdate(input bit rst, input bit mv, input bit m, input bit inh, input bit ack);
    logic [4:0] qMask, hMask, fMask;
    int  nSteps, s;
    bit  setIrq;
    setIrq = 1'b0;
    eQ = 1'b0; eH = 1'b0; eF = 1'b0;
    if (rst) begin
      mMode = 1'b0;
      mCnt  = 0;
      mIrq  = 1'b0;
    end else begin
      nSteps = mMode ? 5 : 4;
      s      = (mCnt / N) % nSteps;
      if (mv) begin
        mMode = m;
        mCnt  = 0;
        eQ    = m;
        eH    = m;
      end else begin
        if ((mCnt % N) == N - 1) begin
          qMask = mMode ? 5'b10111 : 5'b01111;
          hMask = mMode ? 5'b10010 : 5'b01010;
          fMask = mMode ? 5'b10000 : 5'b01000;
          eQ = qMask[s];
          eH = hMask[s];
          eF = fMask[s];
          setIrq = !mMode && (s == 3);
        end
        mCnt = (mCnt + 1) % (N * 20);
      end
      if (inh)         mIrq = 1'b0;
      else if (setIrq) mIrq = 1'b1;
      else if (ack)    mIrq = 1'b0;
    end
    eStep = (mCnt / N) % (mMode ? 5 : 4);
  endtask

  task automatic applyStimulus(input bit rst, input bit mv, input bit m, input bit inh, input bit ack);
    rstIn       = rst;
    modeValidIn = mv;
    modeIn      = m;
    inhibitIn   = inh;
    ackIn       = ack;
    modelUpdate(rst, mv, m, inh, ack);
    @(posedge clk);
    #1;
    checkOutput("quarter", 32'(quarterOut), 32'(eQ));
    checkOutput("half",    32'(halfOut),    32'(eH));
    checkOutput("frame",   32'(frameOut),   32'(eF));
    checkOutput("irq",     32'(irqOut),     32'(mIrq));
    checkOutput("step",    32'(stepOut),    32'(eStep));
  endtask

  initial begin
    int firstQ, firstF;
    bit inh;
    int qCnt, hCnt, fCnt, widthErr, lastF, minGap;
    bit prevQ, prevH, prevF;

    // Reset state and free-running 4-step with directed ack/inhibit events
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    firstQ = -1;
    firstF = -1;
    for (int n = 1; n <= 66; n++) begin
      applyStimulus(0, 0, 0, (n == 49 || n == 50 || (n >= 61 && n <= 64)),
                    (n == 32 || n == 36));
      if (quarterOut && firstQ < 0) firstQ = n;
      if (frameOut && firstF < 0) firstF = n;
    end
    checkOutput("first_quarter_edge", 32'(firstQ), 32'd4);
    checkOutput("first_frame_edge",   32'(firstF), 32'd16);

    // 5-step mode write, then a 4-step write landing on the step-1 tick
    applyStimulus(0, 1, 1, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(0, (k == 8), 0, 0, 0);
    end

    // Randomized mix of mode writes, acks, inhibit and occasional resets
    inh = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 39) == 0) inh = ~inh;
      applyStimulus(($urandom_range(0, 699) == 0), ($urandom_range(0, 149) == 0),
                    1'($urandom_range(0, 1)), inh, ($urandom_range(0, 7) == 0));
    end

    // Long 4-step run of 1000 steps with random acks
    applyStimulus(1, 0, 0, 0, 0);
    qCnt = 0; hCnt = 0; fCnt = 0; widthErr = 0;
    lastF = -1; minGap = 1 << 30;
    prevQ = 1'b0; prevH = 1'b0; prevF = 1'b0;
    for (int n = 1; n <= 1000 * N; n++) begin
      applyStimulus(0, 0, 0, 0, ($urandom_range(0, 5) == 0));
      if (quarterOut) qCnt++;
      if (halfOut) hCnt++;
      if (frameOut) begin
        fCnt++;
        if (lastF >= 0 && (n - lastF) < minGap) minGap = n - lastF;
        lastF = n;
      end
      if ((quarterOut && prevQ) || (halfOut && prevH) || (frameOut && prevF)) widthErr++;
      prevQ = quarterOut;
      prevH = halfOut;
      prevF = frameOut;
    end
    checkOutput("long_quarter_count", 32'(qCnt), 32'd1000);
    checkOutput("long_half_count",    32'(hCnt), 32'd500);
    checkOutput("long_frame_count",   32'(fCnt), 32'd250);
    checkOutput("long_width_errors",  32'(widthErr), 32'd0);
    checkOutput("long_min_frame_gap", 32'(minGap), 32'(4 * N));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
